// File: rtl/l2c_mem_pkg.sv
// Shared L2C array geometry and the state encoding of the array responder.
package l2c_mem_pkg;

  localparam int unsigned L2C_WAY_NUM = 4;
  localparam int unsigned L2C_INDEX_W = 8;
  localparam int unsigned L2C_TAG_W   = 18;
  localparam int unsigned CORE_DATA_W = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    StInit   = 2'd0,
    StIdle   = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } l2c_mem_st_e;

endpackage

// File: rtl/l2c_ram.sv
// Single-port synchronous RAM; rdata only updates on reads, so it keeps the
// pre-write contents across a write cycle.
module l2c_ram #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/l2c_mem.sv
// L2C array responder: per-way tag/valid/dirty/data RAMs, one read-before-write
// transaction per request, valid/dirty swept clear after reset.
module l2c_mem
  import l2c_mem_pkg::*;
#(
  parameter int unsigned WAY_NUM = L2C_WAY_NUM,
  parameter int unsigned INDEX_W = L2C_INDEX_W,
  parameter int unsigned TAG_W   = L2C_TAG_W,
  parameter int unsigned DATA_W  = CORE_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      rw_req,
  input  logic [INDEX_W-1:0]        rw_index,
  input  logic [WAY_NUM-1:0]        wr_en_pack,
  input  logic [TAG_W*WAY_NUM-1:0]  wr_tag_pack,
  input  logic [WAY_NUM-1:0]        wr_valid_pack,
  input  logic [WAY_NUM-1:0]        wr_dirty_pack,
  input  logic [DATA_W*WAY_NUM-1:0] wr_data_pack,
  output logic                      rw_rdy,
  output logic [TAG_W*WAY_NUM-1:0]  rd_tag_pack,
  output logic [WAY_NUM-1:0]        rd_valid_pack,
  output logic [WAY_NUM-1:0]        rd_dirty_pack,
  output logic [DATA_W*WAY_NUM-1:0] rd_data_pack
);

  localparam int unsigned CntW = INDEX_W + 1;

  l2c_mem_st_e st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [INDEX_W-1:0]        idx_q;
  logic [WAY_NUM-1:0]        wen_q;
  logic [TAG_W*WAY_NUM-1:0]  wtag_q;
  logic [WAY_NUM-1:0]        wvalid_q;
  logic [WAY_NUM-1:0]        wdirty_q;
  logic [DATA_W*WAY_NUM-1:0] wdata_q;

  logic [TAG_W*WAY_NUM-1:0]  rd_tag_q;
  logic [WAY_NUM-1:0]        rd_valid_q;
  logic [WAY_NUM-1:0]        rd_dirty_q;
  logic [DATA_W*WAY_NUM-1:0] rd_data_q;

  logic [TAG_W*WAY_NUM-1:0]  tag_rd;
  logic [WAY_NUM-1:0]        valid_rd;
  logic [WAY_NUM-1:0]        dirty_rd;
  logic [DATA_W*WAY_NUM-1:0] data_rd;

  logic               in_init;
  logic               accept;
  logic               do_write;
  logic [INDEX_W-1:0] ram_addr;

  assign in_init  = (st_q == StInit);
  assign accept   = (st_q == StIdle) && rw_req;
  assign do_write = (st_q == StAccess);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      StInit: begin
        cnt_d = cnt_q + CntW'(1);
        // Extra counter bit flags the sweep past the last index.
        if (cnt_d[INDEX_W]) begin
          st_d = StIdle;
        end
      end
      StIdle: begin
        if (rw_req) begin
          st_d = StAccess;
        end
      end
      StAccess: st_d = StResp;
      StResp:   st_d = StIdle;
      default:  st_d = StInit;
    endcase
  end

  always_comb begin
    ram_addr = idx_q;
    if (in_init) begin
      ram_addr = cnt_q[INDEX_W-1:0];
    end else if (st_q == StIdle) begin
      ram_addr = rw_index;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      st_q  <= StInit;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      idx_q    <= '0;
      wen_q    <= '0;
      wtag_q   <= '0;
      wvalid_q <= '0;
      wdirty_q <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      idx_q    <= rw_index;
      wen_q    <= wr_en_pack;
      wtag_q   <= wr_tag_pack;
      wvalid_q <= wr_valid_pack;
      wdirty_q <= wr_dirty_pack;
      wdata_q  <= wr_data_pack;
    end
  end

  // Captured at the ACCESS edge, alongside the write: read-before-write.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_tag_q   <= '0;
      rd_valid_q <= '0;
      rd_dirty_q <= '0;
      rd_data_q  <= '0;
    end else if (do_write) begin
      rd_tag_q   <= tag_rd;
      rd_valid_q <= valid_rd;
      rd_dirty_q <= dirty_rd;
      rd_data_q  <= data_rd;
    end
  end

  assign rw_rdy        = (st_q == StResp);
  assign rd_tag_pack   = rw_rdy ? rd_tag_q   : '0;
  assign rd_valid_pack = rw_rdy ? rd_valid_q : '0;
  assign rd_dirty_pack = rw_rdy ? rd_dirty_q : '0;
  assign rd_data_pack  = rw_rdy ? rd_data_q  : '0;

  for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
    logic way_we;
    logic td_en;
    logic vd_en;
    logic vd_we;

    assign way_we = do_write && wen_q[w];
    assign td_en  = accept || way_we;
    // Valid/dirty are also written with zero throughout the INIT sweep.
    assign vd_en  = in_init || accept || way_we;
    assign vd_we  = in_init || way_we;

    l2c_ram #(
      .WIDTH   (TAG_W),
      .DEPTH_W (INDEX_W)
    ) u_tag (
      .clk   (clk),
      .en    (td_en),
      .we    (way_we),
      .addr  (ram_addr),
      .wdata (wtag_q[w*TAG_W +: TAG_W]),
      .rdata (tag_rd[w*TAG_W +: TAG_W])
    );

    l2c_ram #(
      .WIDTH   (DATA_W),
      .DEPTH_W (INDEX_W)
    ) u_data (
      .clk   (clk),
      .en    (td_en),
      .we    (way_we),
      .addr  (ram_addr),
      .wdata (wdata_q[w*DATA_W +: DATA_W]),
      .rdata (data_rd[w*DATA_W +: DATA_W])
    );

    l2c_ram #(
      .WIDTH   (1),
      .DEPTH_W (INDEX_W)
    ) u_valid (
      .clk   (clk),
      .en    (vd_en),
      .we    (vd_we),
      .addr  (ram_addr),
      .wdata (in_init ? DISABLE : wvalid_q[w]),
      .rdata (valid_rd[w])
    );

    l2c_ram #(
      .WIDTH   (1),
      .DEPTH_W (INDEX_W)
    ) u_dirty (
      .clk   (clk),
      .en    (vd_en),
      .we    (vd_we),
      .addr  (ram_addr),
      .wdata (in_init ? DISABLE : wdirty_q[w]),
      .rdata (dirty_rd[w])
    );
  end

endmodule

// File: tb/tb_l2c_mem.sv
// Directed self-checking bench for l2c_mem: init sweep, full/partial writes,
// back-to-back timing, async reset abort and last-index aliasing.
module tb_l2c_mem;

  logic          clk;
  logic          rst_;
  logic          rw_req;
  logic [7:0]    rw_index;
  logic [3:0]    wr_en_pack;
  logic [71:0]   wr_tag_pack;
  logic [3:0]    wr_valid_pack;
  logic [3:0]    wr_dirty_pack;
  logic [127:0]  wr_data_pack;
  logic          rw_rdy;
  logic [71:0]   rd_tag_pack;
  logic [3:0]    rd_valid_pack;
  logic [3:0]    rd_dirty_pack;
  logic [127:0]  rd_data_pack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [71:0]  cap_tag;
  logic [3:0]   cap_valid;
  logic [3:0]   cap_dirty;
  logic [127:0] cap_data;

  l2c_mem u_dut (
    .clk           (clk),
    .rst_          (rst_),
    .rw_req        (rw_req),
    .rw_index      (rw_index),
    .wr_en_pack    (wr_en_pack),
    .wr_tag_pack   (wr_tag_pack),
    .wr_valid_pack (wr_valid_pack),
    .wr_dirty_pack (wr_dirty_pack),
    .wr_data_pack  (wr_data_pack),
    .rw_rdy        (rw_rdy),
    .rd_tag_pack   (rd_tag_pack),
    .rd_valid_pack (rd_valid_pack),
    .rd_dirty_pack (rd_dirty_pack),
    .rd_data_pack  (rd_data_pack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one transaction and capture the rd_* outputs of its rw_rdy pulse.
  task automatic txn(input logic [7:0] idx, input logic [3:0] wen, input logic [71:0] tags,
                     input logic [3:0] v, input logic [3:0] d, input logic [127:0] data);
    bit got;
    got = 1'b0;
    @(negedge clk);
    rw_index      = idx;
    wr_en_pack    = wen;
    wr_tag_pack   = tags;
    wr_valid_pack = v;
    wr_dirty_pack = d;
    wr_data_pack  = data;
    rw_req        = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      #1;
      if (rw_rdy) begin
        got       = 1'b1;
        cap_tag   = rd_tag_pack;
        cap_valid = rd_valid_pack;
        cap_dirty = rd_dirty_pack;
        cap_data  = rd_data_pack;
      end
    end
    rw_req     = 1'b0;
    wr_en_pack = 4'b0000;
    if (!got) check_val("txn_timeout", 128'd0, 128'd1);
  endtask

  localparam logic [71:0]  Tags2A = {18'h10003, 18'h10002, 18'h10001, 18'h10000};
  localparam logic [127:0] Data2A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] DataPw = {32'h55555555, 32'h55555555, 32'hDEADBEEF, 32'h55555555};
  localparam logic [127:0] DataRm = {32'hA3, 32'hA2, 32'hDEADBEEF, 32'hA0};
  localparam logic [71:0]  TagsFF = {18'h3FFFF, 18'h2ABCD, 18'h12345, 18'h00FF0};
  localparam logic [127:0] DataFF = {32'hF3F3F3F3, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rdy;
    int pulses;
    int last;
    int spacing_bad;
    int zero_bad;
    bit pend;
    bit got;
    logic [7:0] b2b_idx [3];
    logic [3:0] b2b_val [3];

    rst_          = 1'b0;
    rw_req        = 1'b0;
    rw_index      = 8'h00;
    wr_en_pack    = 4'b0000;
    wr_tag_pack   = '0;
    wr_valid_pack = 4'b0000;
    wr_dirty_pack = 4'b0000;
    wr_data_pack  = '0;
    repeat (3) @(negedge clk);
    check_val("reset_rdy", {127'd0, rw_rdy}, 128'd0);
    check_val("reset_rd_data", rd_data_pack, 128'd0);

    // Init sweep: request held from the start, first pulse at edge 258.
    rw_index = 8'h2A;
    rw_req   = 1'b1;
    rst_     = 1'b1;
    first_rdy = 0;
    for (int cyc = 1; cyc <= 300 && first_rdy == 0; cyc++) begin
      @(posedge clk);
      #1;
      if (rw_rdy) begin
        first_rdy = cyc;
        cap_valid = rd_valid_pack;
        cap_dirty = rd_dirty_pack;
      end
    end
    rw_req = 1'b0;
    check_val("init_first_rdy_cycle", 128'(first_rdy), 128'd258);
    check_val("init_valid", 128'(cap_valid), 128'h0);
    check_val("init_dirty", 128'(cap_dirty), 128'h0);

    // Full write then read back.
    txn(8'h2A, 4'b1111, Tags2A, 4'b1111, 4'b0101, Data2A);
    txn(8'h2A, 4'b0000, '0, 4'b0000, 4'b0000, '0);
    check_val("full_tag", 128'(cap_tag), 128'(Tags2A));
    check_val("full_data", cap_data, Data2A);
    check_val("full_valid", 128'(cap_valid), 128'hF);
    check_val("full_dirty", 128'(cap_dirty), 128'h5);

    // Partial write of way 1: response shows the old contents.
    txn(8'h2A, 4'b0010, Tags2A, 4'b0010, 4'b0010, DataPw);
    check_val("pw_old_way1", 128'(cap_data[63:32]), 128'hA1);
    check_val("pw_old_dirty", 128'(cap_dirty), 128'h5);
    txn(8'h2A, 4'b0000, '0, 4'b0000, 4'b0000, '0);
    check_val("pw_data", cap_data, DataRm);
    check_val("pw_tag", 128'(cap_tag), 128'(Tags2A));
    check_val("pw_dirty", 128'(cap_dirty), 128'h7);
    check_val("pw_valid", 128'(cap_valid), 128'hF);

    // Back-to-back reads with the request held high.
    b2b_idx[0] = 8'h2A; b2b_idx[1] = 8'h00; b2b_idx[2] = 8'h2A;
    b2b_val[0] = 4'hF;  b2b_val[1] = 4'h0;  b2b_val[2] = 4'hF;
    pulses = 0; last = 0; spacing_bad = 0; zero_bad = 0; pend = 1'b0;
    @(negedge clk);
    rw_index = b2b_idx[0];
    rw_req   = 1'b1;
    for (int cyc = 1; cyc <= 15 && pulses < 3; cyc++) begin
      @(posedge clk);
      #1;
      if (pend) begin
        rw_index = b2b_idx[pulses];
        pend     = 1'b0;
      end
      if (rw_rdy) begin
        check_val($sformatf("b2b_valid%0d", pulses), 128'(rd_valid_pack), 128'(b2b_val[pulses]));
        if (pulses > 0 && cyc - last != 3) spacing_bad++;
        last = cyc;
        pulses++;
        pend = (pulses < 3);
      end else if (rd_tag_pack != '0 || rd_data_pack != '0 || rd_valid_pack != '0 ||
                   rd_dirty_pack != '0) begin
        zero_bad++;
      end
    end
    rw_req = 1'b0;
    check_val("b2b_pulses", 128'(pulses), 128'd3);
    check_val("b2b_spacing", 128'(spacing_bad), 128'd0);
    check_val("b2b_zero_between", 128'(zero_bad), 128'd0);
    @(posedge clk);
    #1;
    check_val("b2b_pulse_width", {127'd0, rw_rdy}, 128'd0);

    // Reset during RESP drops the outputs asynchronously.
    @(negedge clk);
    rw_index = 8'h2A;
    rw_req   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk);
      #1;
      got = rw_rdy;
    end
    check_val("resp_reached", {127'd0, got}, 128'd1);
    #1;
    rst_ = 1'b0;
    #1;
    check_val("rst_resp_rdy", {127'd0, rw_rdy}, 128'd0);
    check_val("rst_resp_valid", 128'(rd_valid_pack), 128'h0);
    check_val("rst_resp_data", rd_data_pack, 128'd0);

    // Reset while a write to 8'h10 sits in ACCESS (edge 257 after release).
    rw_index      = 8'h10;
    wr_en_pack    = 4'b1111;
    wr_tag_pack   = TagsFF;
    wr_valid_pack = 4'b1111;
    wr_dirty_pack = 4'b1111;
    wr_data_pack  = DataFF;
    @(negedge clk);
    rst_ = 1'b1;
    repeat (257) @(posedge clk);
    #1;
    rst_ = 1'b0;
    #1;
    check_val("rst_access_rdy", {127'd0, rw_rdy}, 128'd0);
    check_val("rst_access_tag", 128'(rd_tag_pack), 128'd0);
    rw_req     = 1'b0;
    wr_en_pack = 4'b0000;
    @(negedge clk);
    rst_ = 1'b1;
    txn(8'h10, 4'b0000, '0, 4'b0000, 4'b0000, '0);
    check_val("reinit_valid_10", 128'(cap_valid), 128'h0);
    check_val("reinit_dirty_10", 128'(cap_dirty), 128'h0);
    txn(8'h2A, 4'b0000, '0, 4'b0000, 4'b0000, '0);
    check_val("reinit_valid_2a", 128'(cap_valid), 128'h0);
    check_val("reinit_tag_kept", 128'(cap_tag), 128'(Tags2A));
    check_val("reinit_data_kept", cap_data, DataRm);

    // Last index, no aliasing onto index 0.
    txn(8'hFF, 4'b1111, TagsFF, 4'b1011, 4'b1000, DataFF);
    txn(8'h00, 4'b0000, '0, 4'b0000, 4'b0000, '0);
    check_val("alias_valid_00", 128'(cap_valid), 128'h0);
    txn(8'hFF, 4'b0000, '0, 4'b0000, 4'b0000, '0);
    check_val("ff_tag", 128'(cap_tag), 128'(TagsFF));
    check_val("ff_data", cap_data, DataFF);
    check_val("ff_valid", 128'(cap_valid), 128'hB);
    check_val("ff_dirty", 128'(cap_dirty), 128'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
